nvm_cmd_responder: RTL
======================

// Module: nvm_cmd_responder
// PURPOSE
//  Target-side endpoint of the nvmain ASCII command interface (command_enable + arg0..arg4).
//  Queues commands, decodes the opcode character, and executes against a small word store with configurable latency.
//  Returns acknowledged results on a valid/ready response channel.
//  Used as an in-RTL stand-in for the VPI nvmain model and as the DUT for command-stream benches.
// PARAMETERS
//  FIFO_DEPTH  4   command queue entries, power of 2
//  MEM_WORDS   16  32-bit store entries, indexed by arg2[log2(MEM_WORDS)-1:0]
//  READ_LAT    4   EXEC cycles for read, >=1
//  WRITE_LAT   6   EXEC cycles for write, >=1
//  MISC_LAT    1   EXEC cycles for cycle/abort/unknown, >=1
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  command_enable in   1   one command captured per high cycle
//  arg0           in   8   ASCII opcode
//  arg1           in   32  issuer cycle stamp, echoed in resp_stamp
//  arg2           in   32  address
//  arg3           in   32  write data
//  arg4           in   8   ASCII tag, echoed in resp_tag
//  cmd_full       out  1   FIFO full; a command presented while full is dropped
//  overflow       out  1   sticky drop flag, cleared only by reset
//  resp_valid     out  1   response available
//  resp_ready     in   1   response consumed when valid&ready
//  resp_opcode    out  8   arg0 of the completed command
//  resp_stamp     out  32  arg1 of the completed command
//  resp_tag       out  8   arg4 of the completed command
//  resp_data      out  32  read data / cycle count / flush count
//  resp_error     out  1   unknown opcode
//  stat_count     out  32  completed-command counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FIFO empty, FSM IDLE, store zeroed, cycle counter 0. All outputs 0.
//  Reset asserted mid-operation abandons the in-flight command with no response.
//  Opcodes (case selects mode):
//   c/C = CYCLE: resp_data = free-running 32-bit cycle counter, wraps.
//   r/R = READ: resp_data = mem[idx].
//   w/W = WRITE: mem[idx] <= arg3 at EXEC end; resp_data = arg3.
//   a/A = ABORT: flush all queued entries; resp_data = number flushed.
//  Uppercase = acknowledged (produces a response). Lowercase = posted (no response).
//  Any other arg0 byte: always acknowledged, resp_error=1, resp_data=0, store untouched.
//  Capture: an entry is written at the edge where command_enable=1 and FIFO not full.
//   A simultaneous pop and push while full still drops the push (full is sampled pre-edge).
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: pops when not empty; loads latency counter.
//   EXEC: counts down LAT cycles, then side effects apply.
//    Acknowledged -> RESP; posted -> IDLE.
//   RESP: resp_* held stable while resp_valid=1 and resp_ready=0; ready -> IDLE.
//  Latency: empty FIFO, idle FSM -> resp_valid rises LAT+1 cycles after the capture edge.
//  ABORT flushes at its EXEC end; commands captured during its EXEC are flushed too.
//  cmd_full = (count==FIFO_DEPTH), combinational from registered count.
// CONFIGURATION
//  NVM_RESP_STATS_EN defined: stat_count increments on every completed command (posted or acknowledged), wraps.
//  NVM_RESP_STATS_EN undefined: stat_count tied to 0; no counter logic.
// STRUCTURE
//  nvm_cmd_pkg holds:
//   ASCII opcode constants;
//   FSM state enum {IDLE, EXEC, RESP};
//   cmd entry struct {op, stamp, addr, data, tag}.
//  Sub-module nvm_cmd_fifo (FIFO_DEPTH x entry, push/pop/flush, count, full, empty).
// TESTING
//  1. 'W' addr=191991292 data=12331 tag='X' -> resp after 7 cycles: op=0x57, data=12331, tag=0x58, err=0.
//  2. Then 'R' same addr (idx 12) -> resp after 5 cycles with data=12331.
//     'r' same addr -> no response.
//  3. Five back-to-back command_enable cycles with a stalled FSM -> 4 queued, overflow=1, cmd_full=1.
//  4. 'C' stamp=384 with resp_ready held low 10 cycles -> resp stable throughout.
//     resp_stamp=384; resp_data = counter value at EXEC end.
//  5. 'A' queued ahead of 3 'R's -> resp_data=3; no read responses follow.
//     arg0=0x5A -> resp_error=1.
//  6. rst_n low during EXEC of 'W' -> no response; mem[idx]=0 after reset.
//     With NVM_RESP_STATS_EN, 3 completed commands -> stat_count=3.

Source files
------------

// File: rtl/nvm_cmd_pkg.sv
// nvm_cmd_pkg
//   Shared definitions for the nvmain ASCII command responder: opcode
//   characters, the FSM state enum, the decoded operation kind and the
//   command entry carried through the queue.
//   No ports; imported by nvm_cmd_fifo and nvm_cmd_responder.

package nvm_cmd_pkg;

  // Opcode characters. Uppercase asks for a response, lowercase is posted.
  localparam logic [7:0] OP_CYCLE_ACK  = 8'h43;  // 'C'
  localparam logic [7:0] OP_CYCLE_POST = 8'h63;  // 'c'
  localparam logic [7:0] OP_READ_ACK   = 8'h52;  // 'R'
  localparam logic [7:0] OP_READ_POST  = 8'h72;  // 'r'
  localparam logic [7:0] OP_WRITE_ACK  = 8'h57;  // 'W'
  localparam logic [7:0] OP_WRITE_POST = 8'h77;  // 'w'
  localparam logic [7:0] OP_ABORT_ACK  = 8'h41;  // 'A'
  localparam logic [7:0] OP_ABORT_POST = 8'h61;  // 'a'

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    KIND_CYCLE,
    KIND_READ,
    KIND_WRITE,
    KIND_ABORT,
    KIND_UNKNOWN
  } op_kind_e;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] stamp;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  tag;
  } cmd_entry_t;

  // Case-insensitive mapping of the opcode byte onto an operation.
  function automatic op_kind_e decodeOp(input logic [7:0] op);
    op_kind_e kind;
    case (op)
      OP_CYCLE_ACK, OP_CYCLE_POST: kind = KIND_CYCLE;
      OP_READ_ACK,  OP_READ_POST:  kind = KIND_READ;
      OP_WRITE_ACK, OP_WRITE_POST: kind = KIND_WRITE;
      OP_ABORT_ACK, OP_ABORT_POST: kind = KIND_ABORT;
      default:                     kind = KIND_UNKNOWN;
    endcase
    return kind;
  endfunction

  // Only the four lowercase known opcodes are posted; unknown bytes are
  // always acknowledged so the issuer learns about the error.
  function automatic logic isPosted(input logic [7:0] op);
    return (op == OP_CYCLE_POST) || (op == OP_READ_POST) ||
           (op == OP_WRITE_POST) || (op == OP_ABORT_POST);
  endfunction

endpackage

// File: rtl/nvm_cmd_fifo.sv
// nvm_cmd_fifo
//   DEPTH-entry command queue with push, pop and flush.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     push_i        write entry_i when not full (full sampled before the edge)
//     entry_i       command entry to queue
//     pop_i         drop the head entry when not empty
//     flush_i       discard every queued entry
//     entry_o       head entry
//     count_o       number of queued entries
//     full_o        count_o == DEPTH
//     empty_o       count_o == 0

module nvm_cmd_fifo
  import nvm_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  cmd_entry_t               entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output cmd_entry_t               entry_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  cmd_entry_t       store_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign entry_o = store_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Pointer/count update. A flush skips the read pointer to the write
  // pointer, so a push landing on the same edge survives as the only entry.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = wrPtr_q;
      count_d = {{PTR_W{1'b0}}, doPush};
    end else begin
      if (doPop) rdPtr_d = rdPtr_q + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (doPush) store_q[wrPtr_q] <= entry_i;
  end

endmodule

// File: rtl/nvm_cmd_responder.sv
// nvm_cmd_responder
//   Target endpoint of the nvmain ASCII command interface. Commands are
//   queued, executed one at a time against a MEM_WORDS x 32 store with a
//   per-opcode latency, and acknowledged commands return a response on a
//   valid/ready channel.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     command_enable, arg0..arg4  command capture (opcode, stamp, addr, data, tag)
//     cmd_full, overflow          queue full / sticky dropped-command flag
//     resp_valid, resp_ready      response handshake
//     resp_opcode/stamp/tag/data/error   response payload
//     stat_count                  completed-command counter
//   Configuration macro: NVM_RESP_STATS_EN enables stat_count; otherwise it
//   is tied to 0.

module nvm_cmd_responder
  import nvm_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 16,
  parameter int READ_LAT   = 4,
  parameter int WRITE_LAT  = 6,
  parameter int MISC_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        command_enable,
  input  logic [7:0]  arg0,
  input  logic [31:0] arg1,
  input  logic [31:0] arg2,
  input  logic [31:0] arg3,
  input  logic [7:0]  arg4,
  output logic        cmd_full,
  output logic        overflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_opcode,
  output logic [31:0] resp_stamp,
  output logic [7:0]  resp_tag,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] stat_count
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LAT_W = 16;
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  state_e                       state_q, state_d;
  cmd_entry_t                   pushEntry, headEntry, cur_q;
  logic                         fifoPop, fifoFlush, fifoFull, fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0]  fifoCount;
  op_kind_e                     curKind;
  logic                         curPosted;
  logic [IDX_W-1:0]             curIdx;
  logic [LAT_W-1:0]             latCnt_q;
  logic                         execDone;
  logic [31:0]                  execData;
  logic [31:0]                  mem_q [MEM_WORDS];
  logic [31:0]                  cycleCnt_q;
  logic                         overflow_q;
  logic [7:0]                   respOp_q, respTag_q;
  logic [31:0]                  respStamp_q, respData_q;
  logic                         respErr_q;

  // Counter preload is LAT-1 so that EXEC occupies exactly LAT cycles.
  function automatic logic [LAT_W-1:0] latLoad(input op_kind_e kind);
    case (kind)
      KIND_READ:  return LAT_W'(READ_LAT - 1);
      KIND_WRITE: return LAT_W'(WRITE_LAT - 1);
      default:    return LAT_W'(MISC_LAT - 1);
    endcase
  endfunction

  assign pushEntry = '{op: arg0, stamp: arg1, addr: arg2, data: arg3, tag: arg4};
  assign curKind   = decodeOp(cur_q.op);
  assign curPosted = isPosted(cur_q.op);
  assign curIdx    = cur_q.addr[IDX_W-1:0];

  nvm_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (command_enable),
    .entry_i (pushEntry),
    .pop_i   (fifoPop),
    .flush_i (fifoFlush),
    .entry_o (headEntry),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: posted commands skip RESP and go straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifoEmpty) state_d = EXEC;
      EXEC:    if (latCnt_q == '0) state_d = curPosted ? IDLE : RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. The abort flush fires on the same edge as its side effects.
  always_comb begin
    fifoPop    = (state_q == IDLE) && !fifoEmpty;
    execDone   = (state_q == EXEC) && (latCnt_q == '0);
    fifoFlush  = execDone && (curKind == KIND_ABORT);
    resp_valid = (state_q == RESP);
  end

  // Result of the executing command; abort reports the entries it flushes.
  always_comb begin
    execData = '0;
    case (curKind)
      KIND_CYCLE: execData = cycleCnt_q;
      KIND_READ:  execData = mem_q[curIdx];
      KIND_WRITE: execData = cur_q.data;
      KIND_ABORT: execData = 32'(fifoCount);
      default:    execData = '0;
    endcase
  end

  // Command datapath: latch the popped command, run the latency counter,
  // and capture the response payload only for acknowledged commands so it
  // stays untouched while a response waits for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= '0;
      latCnt_q    <= '0;
      cycleCnt_q  <= '0;
      overflow_q  <= 1'b0;
      respOp_q    <= '0;
      respStamp_q <= '0;
      respTag_q   <= '0;
      respData_q  <= '0;
      respErr_q   <= 1'b0;
    end else begin
      cycleCnt_q <= cycleCnt_q + 32'd1;
      if (command_enable && fifoFull) overflow_q <= 1'b1;
      if (fifoPop) begin
        cur_q    <= headEntry;
        latCnt_q <= latLoad(decodeOp(headEntry.op));
      end else if ((state_q == EXEC) && (latCnt_q != '0)) begin
        latCnt_q <= latCnt_q - LAT_ONE;
      end
      if (execDone && !curPosted) begin
        respOp_q    <= cur_q.op;
        respStamp_q <= cur_q.stamp;
        respTag_q   <= cur_q.tag;
        respData_q  <= execData;
        respErr_q   <= (curKind == KIND_UNKNOWN);
      end
    end
  end

  // Word store; writes land at the end of the write's EXEC phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (execDone && (curKind == KIND_WRITE)) begin
      mem_q[curIdx] <= cur_q.data;
    end
  end

`ifdef NVM_RESP_STATS_EN
  logic [31:0] statCnt_q;

  // Every command that finishes EXEC counts, posted or acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        statCnt_q <= '0;
    else if (execDone) statCnt_q <= statCnt_q + 32'd1;
  end

  assign stat_count = statCnt_q;
`else
  assign stat_count = '0;
`endif

  assign cmd_full    = fifoFull;
  assign overflow    = overflow_q;
  assign resp_opcode = respOp_q;
  assign resp_stamp  = respStamp_q;
  assign resp_tag    = respTag_q;
  assign resp_data   = respData_q;
  assign resp_error  = respErr_q;

endmodule
